// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants, tag type and saturating-add helper for the
//            fetch latency buffer.
// Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } fetch_tag_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_resp_fifo
// Purpose  : DEPTH x WIDTH synchronous circular FIFO with flush, occupancy
//            count and simultaneous push/pop at any fill level.
// Revision : 1.0  initial release
// ============================================================================
module fetch_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_latency_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_latency_buffer
// Purpose  : Issues fetches to a fixed-latency BRAM, tracks them in a tag pipe
//            and queues responses; redirect kills all stale instructions.
//            Optional macro FETCH_PERF_CNT_EN adds perf counter outputs.
// Revision : 1.0  initial release
// ============================================================================
module fetch_latency_buffer
    import fetch_pkg::*;
#(
    parameter int          LAT   = 2,
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_pc_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        redirect_i,
    input  logic        deq_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    output logic        mem_en_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_issued_o,
    output logic [31:0] perf_killed_o,
    output logic [31:0] perf_bubble_o
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(LAT + DEPTH + 1);

    generate
        if (LAT < LAT_MIN || LAT > LAT_MAX || DEPTH < LAT + 1) begin : g_bad_params
            $error("fetch_latency_buffer: illegal LAT/DEPTH combination");
        end
    endgenerate

    fetch_tag_t       tag_q [LAT];
    fetch_tag_t       tag_d [LAT];
    logic [OUT_W-1:0] tags_valid_cnt;
    logic [OUT_W-1:0] outstanding;
    logic [CNT_W-1:0] fifo_count;
    logic [63:0]      fifo_head;
    logic             fifo_empty;
    logic             issue;
    logic             resp_push;
    logic             resp_pop;

    // Credit: every in-flight tag already owns a FIFO slot, so pushes never overflow.
    always_comb begin
        tags_valid_cnt = '0;
        for (int i = 0; i < LAT; i++) begin
            tags_valid_cnt = tags_valid_cnt + OUT_W'(tag_q[i].valid);
        end
        outstanding = tags_valid_cnt + OUT_W'(fifo_count);
        issue       = req_valid_i && !redirect_i && !rst && (outstanding < OUT_W'(DEPTH));
    end

    always_comb begin
        tag_d = tag_q;
        for (int i = LAT - 1; i > 0; i--) begin
            tag_d[i] = tag_q[i - 1];
        end
        tag_d[0].valid = issue;
        tag_d[0].pc    = issue ? req_pc_i : '0;
        if (redirect_i) begin
            for (int i = 0; i < LAT; i++) begin
                tag_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q <= tag_d;
        end
    end

    assign resp_push = tag_q[LAT-1].valid && !redirect_i;
    assign resp_pop  = deq_i && !redirect_i;

    fetch_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_resp_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_i),
        .push_i      (resp_push),
        .push_data_i ({tag_q[LAT-1].pc, mem_rdata_i}),
        .pop_i       (resp_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign req_ready_o   = issue;
    assign mem_en_o      = issue;
    assign mem_addr_o    = issue ? {req_pc_i[31:2], 2'b00} : '0;
    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? NOP : fifo_head[31:0];
    assign instr_pc_o    = fifo_empty ? '0 : fifo_head[63:32];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_killed_q, perf_killed_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    // Everything counted in outstanding is discarded by a redirect.
    always_comb begin
        perf_issued_d = perf_issued_q;
        perf_killed_d = perf_killed_q;
        perf_bubble_d = perf_bubble_q;
        if (issue) begin
            perf_issued_d = sat_add32(perf_issued_q, 32'd1);
        end
        if (redirect_i) begin
            perf_killed_d = sat_add32(perf_killed_q, 32'(outstanding));
        end
        if (deq_i && fifo_empty) begin
            perf_bubble_d = sat_add32(perf_bubble_q, 32'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_q <= '0;
            perf_killed_q <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_killed_q <= perf_killed_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_killed_o = perf_killed_q;
    assign perf_bubble_o = perf_bubble_q;
`endif

endmodule
`default_nettype wire
